cen_frac_multi: RTL and testbench
=================================

// Module: cen_frac_multi
// PURPOSE
// - Parametrised multi-channel fractional clock-enable generator. Successor to the fixed-ratio
//   24 MHz divider that feeds ce_6/ce_2 into system.
// - Each channel emits one-cycle enables at an exact average rate of clk_sys * NUM/DEN.
// - Adds a runtime turbo mode (2x rate, for faster simulation), pause, and a phase resync
//   across all channels.
// - Sits between clk_sys and all cen consumers (CPU, video, sound) in both the emu and sim tops.
// PARAMETERS
// - NUM_CH   4                    number of enable channels
// - ACC_W    24                   accumulator width; elaboration error if DEN[i] >= 2**ACC_W
// - NUM      {24'd1,24'd1,24'd1,24'd1}   packed NUM_CH*ACC_W, channel i numerator at [i*ACC_W +: ACC_W]
// - DEN      {24'd12,24'd4,24'd8,24'd4}  packed denominators, same layout
// - Elaboration error unless 0 < NUM[i] <= DEN[i] for every channel.
// PORTS
// - clk_sys    in   1        system clock, single clock domain
// - reset      in   1        synchronous, active-high
// - pause      in   1        freeze all accumulators, suppress enables
// - turbo      in   1        double every channel's effective numerator
// - resync     in   1        one-cycle strobe: realign all channels to phase 0
// - cen        out  NUM_CH   one-cycle clock-enable pulses, registered
// - cen_count  out  16       free-running count of channel-0 pulses, wraps at 0xFFFF->0
// BEHAVIOUR
// - Reset (synchronous): acc[i]=0, cen=0, cen_count=0. Reset has priority over every other input.
//   Reset asserted mid-operation clears state on the next edge with no residual pulse.
// - Effective numerator: ne[i] = turbo ? min(2*NUM[i], DEN[i]) : NUM[i].
//   Sums are computed at ACC_W+1 bits, so there is no overflow.
// - Per edge, with pause=0 and resync=0:
//   s = acc[i] + ne[i];
//   if s >= DEN[i], then acc[i] <= s - DEN[i] and cen[i] <= 1;
//   otherwise acc[i] <= s and cen[i] <= 0.
// - Latency: with NUM=1, DEN=D, the first pulse is registered on the D-th edge after reset
//   deasserts, then one pulse every D edges.
// - ne == DEN gives cen held high continuously.
// - pause=1: acc holds and cen <= 0. On release, the phase continues exactly where it stopped.
// - resync=1 (pause is don't-care): acc[*] <= 0 and cen <= 0. The next pulse follows the
//   normal latency rule.
// - Priority: reset > resync > pause > count.
// - turbo may toggle at any cycle and takes effect on that same edge.
//   acc is never reset by turbo; because acc < DEN always holds, no burst occurs.
// - Invariant: acc[i] < DEN[i] at all times. The bench asserts this.
// - cen_count increments on each edge where cen[0] is registered high.
// - Long-run accuracy: over any DEN[i]*k unpaused non-turbo cycles starting at acc=0,
//   exactly NUM[i]*k pulses.
// STRUCTURE
// - Package cen_pkg:
//   - localparam CEN_ACC_W_DEFAULT;
//   - function ne_calc(num, den, turbo);
//   - function param_ok(num, den) for the elaboration checks.
// - Sub-module cen_frac_ch: one accumulator channel (ports clk_sys, reset, pause, turbo,
//   resync, cen). Generated NUM_CH times.
// - The top holds the parameter unpacking, the elaboration checks, and cen_count.
// TESTING
// - Ch0 NUM=1, DEN=4, release reset -> cen[0] high on edges 4, 8, 12, ...; cen_count=3 after edge 12.
// - NUM=3, DEN=8 -> acc sequence 3,6,1,4,7,2,5,0; cen pattern 0,0,1,0,0,1,0,1 repeating;
//   exactly 3 pulses per 8 cycles.
// - NUM=1, DEN=4, turbo=1 -> pulse every 2 cycles.
//   NUM=5, DEN=8, turbo=1 -> ne clamps to 8, cen constant high.
//   Toggling turbo mid-stream -> acc < DEN and no double pulse.
// - NUM=1, DEN=4: pause on edge 2 for 10 cycles -> no pulses; first pulse 2 edges after release.
//   resync at acc=3 -> no pulse, next pulse 4 edges later.
// - Reset asserted with acc=2 and resync asserted in the same cycle -> all outputs 0 next edge.
//   cen_count wrap: force 0xFFFF + 1 pulse -> 0x0000.
// - 24 MHz -> NTSC colour clock (NUM=715909, DEN=4800000) over 4,800,000 cycles ->
//   exactly 715909 pulses.

Source files
------------

// File: rtl/cen_frac_multi_pkg.sv
// Shared constants and helpers for the fractional clock-enable generator.
// Helpers work at a fixed 32-bit width so any accumulator width up to 31 bits fits.
package cen_pkg;

  localparam int CEN_ACC_W_DEFAULT = 24;
  localparam int CEN_FN_W          = 32;

  // Effective numerator: turbo doubles the rate but never beyond one pulse per cycle.
  function automatic logic [CEN_FN_W-1:0] ne_calc(
    input logic [CEN_FN_W-1:0] num,
    input logic [CEN_FN_W-1:0] den,
    input logic                turbo
  );
    logic [CEN_FN_W-1:0] dbl;
    dbl = num << 1;
    if (!turbo) return num;
    return (dbl > den) ? den : dbl;
  endfunction

  function automatic logic param_ok(
    input logic [CEN_FN_W-1:0] num,
    input logic [CEN_FN_W-1:0] den,
    input int                  acc_w
  );
    return (num != '0) && (num <= den) && (acc_w >= 1) && (acc_w <= 31) &&
           (den < (32'd1 << acc_w));
  endfunction

endpackage

// File: rtl/cen_frac_multi_ch.sv
// One fractional-rate accumulator channel: emits a registered one-cycle enable
// each time the accumulator crosses DEN, averaging NUM/DEN pulses per cycle.
module cen_frac_ch
  import cen_pkg::*;
#(
  parameter int               ACC_W = CEN_ACC_W_DEFAULT,
  parameter logic [ACC_W-1:0] NUM   = ACC_W'(1),
  parameter logic [ACC_W-1:0] DEN   = ACC_W'(4)
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic pause,
  input  logic turbo,
  input  logic resync,
  output logic cen
);

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] ne;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   diff;
  logic             hit;
  logic             cen_reg;

  assign ne       = ACC_W'(ne_calc(CEN_FN_W'(NUM), CEN_FN_W'(DEN), turbo));
  // One extra bit keeps acc + ne exact; since acc < DEN the wrapped value stays < DEN.
  assign sum      = {1'b0, acc_reg} + {1'b0, ne};
  assign hit      = (sum >= {1'b0, DEN});
  assign diff     = sum - {1'b0, DEN};
  assign acc_next = ACC_W'(hit ? diff : sum);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      acc_reg <= '0;
      cen_reg <= 1'b0;
    end else if (resync) begin
      acc_reg <= '0;
      cen_reg <= 1'b0;
    end else if (pause) begin
      cen_reg <= 1'b0;
    end else begin
      acc_reg <= acc_next;
      cen_reg <= hit;
    end
  end

  assign cen = cen_reg;

endmodule

// File: rtl/cen_frac_multi.sv
// Multi-channel fractional clock-enable generator with turbo, pause and phase resync,
// plus a free-running count of channel-0 pulses.
module cen_frac_multi
  import cen_pkg::*;
#(
  parameter int                      NUM_CH = 4,
  parameter int                      ACC_W  = CEN_ACC_W_DEFAULT,
  parameter logic [NUM_CH*ACC_W-1:0] NUM    = {24'd1, 24'd1, 24'd1, 24'd1},
  parameter logic [NUM_CH*ACC_W-1:0] DEN    = {24'd12, 24'd4, 24'd8, 24'd4}
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              pause,
  input  logic              turbo,
  input  logic              resync,
  output logic [NUM_CH-1:0] cen,
  output logic [15:0]       cen_count
);

  logic [15:0] count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam logic [ACC_W-1:0] NUM_I = NUM[gi*ACC_W +: ACC_W];
      localparam logic [ACC_W-1:0] DEN_I = DEN[gi*ACC_W +: ACC_W];

      if (!param_ok(CEN_FN_W'(NUM_I), CEN_FN_W'(DEN_I), ACC_W)) begin : g_bad
        $error("cen_frac_multi: channel %0d needs 0 < NUM <= DEN < 2**ACC_W", gi);
      end

      cen_frac_ch #(
        .ACC_W (ACC_W),
        .NUM   (NUM_I),
        .DEN   (DEN_I)
      ) u_ch (
        .clk_sys (clk_sys),
        .reset   (reset),
        .pause   (pause),
        .turbo   (turbo),
        .resync  (resync),
        .cen     (cen[gi])
      );
    end
  endgenerate

  // count_reg lags cen[0] by one edge; adding the live pulse makes the count
  // include the pulse registered on the same edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + {15'd0, cen[0]};
    end
  end

  assign cen_count = count_reg + {15'd0, cen[0]};

endmodule

// File: tb/tb_cen_frac_multi.sv
// Self-checking bench: directed scenarios plus randomized pause/turbo/resync/reset
// against an arithmetic reference model; a second 1/1 instance exercises count wrap.
module tb_cen_frac_multi;

  localparam int NCH = 4;
  localparam int AW  = 24;
  localparam logic [NCH*AW-1:0] P_NUM = {24'd7, 24'd5, 24'd3, 24'd1};
  localparam logic [NCH*AW-1:0] P_DEN = {24'd13, 24'd8, 24'd8, 24'd4};

  int unsigned nums [NCH] = '{1, 3, 5, 7};
  int unsigned dens [NCH] = '{4, 8, 8, 13};

  logic            clk_sys = 1'b0;
  logic            reset   = 1'b1;
  logic            pause   = 1'b0;
  logic            turbo   = 1'b0;
  logic            resync  = 1'b0;
  logic [NCH-1:0]  cen;
  logic [15:0]     cen_count;

  logic            w_reset = 1'b1;
  logic            w_pause = 1'b0;
  logic            w_turbo = 1'b0;
  logic            w_resync = 1'b0;
  logic [0:0]      w_cen;
  logic [15:0]     w_count;

  always #5 clk_sys = ~clk_sys;

  cen_frac_multi #(
    .NUM_CH (NCH),
    .ACC_W  (AW),
    .NUM    (P_NUM),
    .DEN    (P_DEN)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .pause     (pause),
    .turbo     (turbo),
    .resync    (resync),
    .cen       (cen),
    .cen_count (cen_count)
  );

  cen_frac_multi #(
    .NUM_CH (1),
    .ACC_W  (8),
    .NUM    (8'd1),
    .DEN    (8'd1)
  ) dut_wrap (
    .clk_sys   (clk_sys),
    .reset     (w_reset),
    .pause     (w_pause),
    .turbo     (w_turbo),
    .resync    (w_resync),
    .cen       (w_cen),
    .cen_count (w_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int w_start  = 0;

  int unsigned     m_acc [NCH];
  logic [NCH-1:0]  m_cen = '0;
  int unsigned     m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference: each channel gains ne per active cycle and pulses whenever it reaches DEN.
  task automatic model_edge();
    int unsigned ne;
    int unsigned s;
    if (reset) begin
      for (int i = 0; i < NCH; i++) m_acc[i] = 0;
      m_cen = '0;
      m_cnt = 0;
    end else if (resync) begin
      for (int i = 0; i < NCH; i++) m_acc[i] = 0;
      m_cen = '0;
    end else if (pause) begin
      m_cen = '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        ne = turbo ? ((2 * nums[i] < dens[i]) ? 2 * nums[i] : dens[i]) : nums[i];
        s  = m_acc[i] + ne;
        m_cen[i] = (s >= dens[i]);
        m_acc[i] = (s >= dens[i]) ? s - dens[i] : s;
      end
      if (m_cen[0]) m_cnt = (m_cnt + 1) % 65536;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_sys);
    #1;
    cyc++;
    check("cen", 32'(cen), 32'(m_cen));
    check("cen_count", 32'(cen_count), m_cnt);
    check("inv_ch0", 32'(dut.g_ch[0].u_ch.acc_reg < 24'd4), 32'd1);
    check("inv_ch1", 32'(dut.g_ch[1].u_ch.acc_reg < 24'd8), 32'd1);
    check("inv_ch2", 32'(dut.g_ch[2].u_ch.acc_reg < 24'd8), 32'd1);
    check("inv_ch3", 32'(dut.g_ch[3].u_ch.acc_reg < 24'd13), 32'd1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] pat1;
    int         ones1;
    int         pc [NCH];

    for (int i = 0; i < NCH; i++) m_acc[i] = 0;
    pat1 = 8'b1010_0100;

    // Reset state, then release the wrap instance.
    step();
    check("reset_cen", 32'(cen), 32'd0);
    check("reset_cnt", 32'(cen_count), 32'd0);
    w_reset = 1'b0;
    w_start = cyc;
    step();

    // 1/4 on ch0, 3/8 pattern on ch1.
    pulse_reset();
    ones1 = 0;
    for (int e = 1; e <= 16; e++) begin
      step();
      check("ch0_div4", 32'(cen[0]), 32'((e % 4) == 0));
      check("ch1_3of8", 32'(cen[1]), 32'(pat1[(e - 1) % 8]));
      ones1 += int'(cen[1]);
      if (e == 12) check("cnt_edge12", 32'(cen_count), 32'd3);
    end
    check("ch1_pulses16", ones1, 32'd6);

    // Turbo: ch0 every 2 cycles, ch2 clamped to continuous.
    pulse_reset();
    turbo = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      check("turbo_ch0", 32'(cen[0]), 32'((e % 2) == 0));
      check("turbo_ch2", 32'(cen[2]), 32'd1);
    end
    turbo = 1'b0;

    // Pause after two edges; phase resumes where it stopped.
    pulse_reset();
    step();
    step();
    pause = 1'b1;
    for (int e = 0; e < 10; e++) begin
      step();
      check("pause_quiet", 32'(cen), 32'd0);
    end
    pause = 1'b0;
    step();
    check("unpause_e1", 32'(cen[0]), 32'd0);
    step();
    check("unpause_e2", 32'(cen[0]), 32'd1);

    // Resync with ch0 at acc=3.
    pulse_reset();
    repeat (3) step();
    resync = 1'b1;
    step();
    check("resync_quiet", 32'(cen), 32'd0);
    resync = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      check("resync_ch0", 32'(cen[0]), 32'(e == 4));
    end

    // Reset and resync together mid-stream.
    pulse_reset();
    repeat (2) step();
    reset  = 1'b1;
    resync = 1'b1;
    step();
    check("rst_resync_cen", 32'(cen), 32'd0);
    check("rst_resync_cnt", 32'(cen_count), 32'd0);
    reset  = 1'b0;
    resync = 1'b0;

    // Long-run accuracy over a common multiple of every DEN.
    pulse_reset();
    for (int i = 0; i < NCH; i++) pc[i] = 0;
    for (int c = 0; c < 1040; c++) begin
      step();
      for (int i = 0; i < NCH; i++) pc[i] += int'(cen[i]);
    end
    for (int i = 0; i < NCH; i++)
      check("longrun_pulses", pc[i], nums[i] * 1040 / dens[i]);

    // Randomized control activity.
    pulse_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) turbo = ~turbo;
      pause  = ($urandom_range(0, 9) == 0);
      resync = ($urandom_range(0, 49) == 0);
      reset  = ($urandom_range(0, 199) == 0);
      step();
    end
    reset  = 1'b0;
    pause  = 1'b0;
    resync = 1'b0;
    turbo  = 1'b0;

    // Count wrap on the always-on instance.
    while (cyc - w_start < 65535) step();
    check("wrap_ffff", 32'(w_count), 32'hFFFF);
    step();
    check("wrap_zero", 32'(w_count), 32'h0);
    check("wrap_cen", 32'(w_cen), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
